// File: rtl/dpram_fifo_ctrl.sv
// Push/pop FIFO controller wrapped around a dual-port RAM with a registered port-B read.
// Port A is the write port, port B the read port; flags are decoded from a registered count.
module dpram_fifo_ctrl #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 4,
   parameter int DEPTH         = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic                     rd_en,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic                     rd_valid,
   output logic                     full,
   output logic                     empty,
   output logic [ADDRESS_WIDTH:0]   count,
   output logic                     overflow,
   output logic                     underflow,
   output logic                     we_a,
   output logic [ADDRESS_WIDTH-1:0] addr_a,
   output logic [DATA_WIDTH-1:0]    data_in_a,
   output logic                     we_b,
   output logic [ADDRESS_WIDTH-1:0] addr_b,
   output logic [DATA_WIDTH-1:0]    data_in_b,
   input  logic [DATA_WIDTH-1:0]    data_out_b
);

   localparam logic [ADDRESS_WIDTH:0] FULL_COUNT = DEPTH[ADDRESS_WIDTH:0];
   localparam logic [ADDRESS_WIDTH:0] ONE        = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

   logic [ADDRESS_WIDTH:0] wr_ptr;
   logic [ADDRESS_WIDTH:0] rd_ptr;
   logic [ADDRESS_WIDTH:0] count_q;
   logic                   push_ok;
   logic                   pop_ok;

   assign full  = (count_q == FULL_COUNT);
   assign empty = (count_q == '0);
   assign count = count_q;

   // Gating with rst_n keeps port A quiet while reset is held.
   assign push_ok = wr_en & ~full  & rst_n;
   assign pop_ok  = rd_en & ~empty & rst_n;

   assign we_a      = push_ok;
   assign addr_a    = wr_ptr[ADDRESS_WIDTH-1:0];
   assign data_in_a = wr_data;
   assign we_b      = 1'b0;
   assign addr_b    = rd_ptr[ADDRESS_WIDTH-1:0];
   assign data_in_b = '0;
   assign rd_data   = data_out_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         rd_valid  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + ONE;
         if (pop_ok)
            rd_ptr <= rd_ptr + ONE;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + ONE;
            2'b01:   count_q <= count_q - ONE;
            default: count_q <= count_q;
         endcase
         rd_valid  <= pop_ok;
         overflow  <= wr_en & full;
         underflow <= rd_en & empty;
      end
   end

endmodule

// File: doc/dpram_fifo_ctrl.md
# dpram_fifo_ctrl

- Single-clock FIFO controller that sits directly upstream of `dpram`.
- Drives port A of `dpram` as the write port and port B as the read port; port B never writes.
- Turns the raw dual-port storage into a push/pop queue with full/empty flags, an occupancy count, and error pulses.
- Consumes `dpram`'s registered port-B read data and returns it with a valid strobe.

## Interface

- `DATA_WIDTH`, default 8: word width; must equal `dpram`'s data width.
- `ADDRESS_WIDTH`, default 4: `dpram` address width.
- `DEPTH`, default 16: entries; must equal 2**`ADDRESS_WIDTH`.

Ports. Single clock `clk`; reset `rst_n` is asynchronous, active-low.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_en`  in  1  push request.
- `wr_data`  in  `DATA_WIDTH`  push data.
- `rd_en`  in  1  pop request.
- `rd_data`  out  `DATA_WIDTH`  popped word; meaningful only while `rd_valid` is 1.
- `rd_valid`  out  1  `rd_data` holds the word of the pop accepted on the previous edge.
- `full`  out  1  count == `DEPTH`.
- `empty`  out  1  count == 0.
- `count`  out  `ADDRESS_WIDTH`+1  occupancy, 0..`DEPTH`.
- `overflow`  out  1  one-cycle pulse: a push was rejected.
- `underflow`  out  1  one-cycle pulse: a pop was rejected.
- `we_a`  out  1  to `dpram` port-A write enable.
- `addr_a`  out  `ADDRESS_WIDTH`  to `dpram` port-A address.
- `data_in_a`  out  `DATA_WIDTH`  to `dpram` port-A write data.
- `we_b`  out  1  to `dpram` port-B write enable; constant 0.
- `addr_b`  out  `ADDRESS_WIDTH`  to `dpram` port-B address.
- `data_in_b`  out  `DATA_WIDTH`  to `dpram` port-B write data; constant 0.
- `data_out_b`  in  `DATA_WIDTH`  from `dpram` port B; registered read, 1-cycle latency.

## Operation

- **Pointers.**
  - `wr_ptr` and `rd_ptr` are `ADDRESS_WIDTH`+1 bits; the MSB is a wrap bit.
  - Memory address = low `ADDRESS_WIDTH` bits.
  - Both pointers increment modulo 2*`DEPTH`.
- **Accept rules.**
  - `push_ok = wr_en & ~full`.
  - `pop_ok = rd_en & ~empty`.
  - Flags are evaluated on pre-edge state.
  - A push while full is rejected even if a pop is accepted in the same cycle.
  - A pop while empty is rejected even if a push is accepted in the same cycle.
- **Memory drive (combinational).**
  - `we_a = push_ok`, `addr_a = wr_ptr[ADDRESS_WIDTH-1:0]`, `data_in_a = wr_data`.
  - `addr_b = rd_ptr[ADDRESS_WIDTH-1:0]`.
- **Count update.**
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - `full`/`empty` are decoded from the registered count; they never glitch mid-cycle.
- **No collision.** Accepted push and pop never target the same address in one cycle: the rules above imply `wr_ptr` != `rd_ptr` whenever both are accepted. Read-during-write behaviour of `dpram` is therefore irrelevant.
- **Read return.**
  - `rd_valid` is registered `pop_ok`.
  - `rd_data = data_out_b` (pass-through).
- **Errors.**
  - `overflow` is registered (`wr_en & full`).
  - `underflow` is registered (`rd_en & empty`).
  - Each is a pulse, not sticky.
- **Reset.**
  - On `rst_n` low, immediately: pointers 0, `count` 0, `empty` 1, `full` 0, `rd_valid` 0, `overflow` 0, `underflow` 0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all entries; stale memory is never exposed because `empty` = 1.
  - An in-flight `rd_valid` is killed.

## Timing

- Push accepted at edge N:
  - Word is written into `dpram` at edge N.
  - `count`/flags update after edge N.
  - Word is poppable from cycle N+1.
- Pop accepted at edge N:
  - `dpram` registers `mem[addr_b]` at edge N.
  - `rd_valid` = 1 and `rd_data` valid during cycle N+1.
  - Back-to-back pops give one word per cycle.
- Write-to-read latency through an empty FIFO:
  - Push at edge N, pop at edge N+1, data visible in cycle N+2.
- Throughput: one push and one pop per cycle simultaneously when 0 < count < `DEPTH`.
- `overflow`/`underflow` are high during the cycle after the offending edge.

## Test plan

- **Reset.** Assert `rst_n` = 0 with random inputs -> `empty` = 1, `full` = 0, `count` = 0, `rd_valid` = 0, `we_b` = 0; no `we_a` pulses.
- **Fill and overflow.**
  - Stimulus: push 0x01..0x10 (16 words), then push 0xAA.
  - Required: `full` = 1 after 16th edge, `count` = 16; 0xAA rejected (`we_a` = 0), `overflow` pulses for exactly 1 cycle, `count` stays 16.
- **Drain and underflow.**
  - Stimulus: pop 17 times back-to-back.
  - Required: `rd_data` = 0x01..0x10 in order, each with `rd_valid` = 1, one cycle after its pop; `empty` = 1 after 16th pop; 17th pop gives `underflow` pulse and `rd_valid` = 0.
- **Simultaneous push/pop.**
  - With `count` = 5: push and pop together for 10 cycles -> `count` stays 5, FIFO order preserved.
  - With `count` = 0: push+pop -> push accepted, pop rejected with `underflow`, `count` = 1.
  - With `count` = 16: push+pop -> pop accepted, push rejected with `overflow`, `count` = 15.
- **Wrap-around.** Push/pop 40 words with `count` kept at 3 -> addresses wrap past 15 to 0 twice; data is bit-exact and in order; `full` never asserts.
- **Reset mid-operation.** At `count` = 7 with a pop issued on the edge before reset -> `rd_valid` forced 0, `empty` = 1; the next push/pop pair returns the new word, not stale data.
